// File: rtl/sccb_target.sv
// SCCB responder: oversampled SIO_C/SIO_D decode, ID/sub-address/data phases, 2**REG_AW x 8 register file.
// Define SCCB_TGT_ACK_EN to drive an I2C-style ACK (0) in the 9th bit of matched ID, sub-address and write bytes.
module sccb_target #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter bit         ADDR16 = 1'b1,
  parameter int         REG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sccb_clk_in,
  input  logic              sccb_data_in,
  output logic              sccb_data_out,
  output logic              sccb_data_en,
  output logic              reg_wr,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [7:0]        reg_wdata,
  input  logic [REG_AW-1:0] loc_addr,
  output logic [7:0]        loc_rdata,
  output logic              busy
);

`ifdef SCCB_TGT_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam int DEPTH = 2 ** REG_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_SUBH, S_SUBL, S_WDATA, S_RDATA, S_WAIT_STOP, S_IGNORE
  } state_t;

  state_t            state;
  logic [2:0]        c_sh, d_sh;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg, sub_hi;
  logic [REG_AW-1:0] ptr;
  logic [7:0]        mem [DEPTH];

  // [1] is the synchronized level, [2] its history; reset to the idle-bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sh <= '1;
      d_sh <= '1;
    end else begin
      c_sh <= {c_sh[1:0], sccb_clk_in};
      d_sh <= {d_sh[1:0], sccb_data_in};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, id_match, ack_slot;
  logic [7:0] rd_byte;
  logic       rd_bit;

  assign scl_rise  =  c_sh[1] & ~c_sh[2];
  assign scl_fall  = ~c_sh[1] &  c_sh[2];
  assign start_det =  c_sh[1] & ~d_sh[1] &  d_sh[2];
  assign stop_det  =  c_sh[1] &  d_sh[1] & ~d_sh[2];
  assign id_match  = (shreg[7:1] == DEV_ID);
  assign ack_slot  = (state == S_ID && id_match) || state == S_SUBH ||
                     state == S_SUBL || state == S_WDATA;
  assign rd_byte   = mem[ptr];
  assign rd_bit    = rd_byte[3'd7 - bit_cnt[2:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      sub_hi        <= '0;
      ptr           <= '0;
      sccb_data_out <= 1'b1;
      sccb_data_en  <= 1'b0;
      reg_wr        <= 1'b0;
      reg_waddr     <= '0;
      reg_wdata     <= '0;
      busy          <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      if (stop_det) begin
        state         <= S_IDLE;
        bit_cnt       <= '0;
        sccb_data_out <= 1'b1;
        sccb_data_en  <= 1'b0;
        busy          <= 1'b0;
      end else if (start_det) begin
        state         <= S_ID;
        bit_cnt       <= '0;
        sccb_data_out <= 1'b1;
        sccb_data_en  <= 1'b0;
      end else if (scl_rise) begin
        if (bit_cnt != 4'd8) begin
          shreg   <= {shreg[6:0], d_sh[1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          // 9th bit: the byte in shreg is complete, act on it
          bit_cnt <= '0;
          case (state)
            S_ID: begin
              if (!id_match) begin
                state <= S_IGNORE;
                busy  <= 1'b0;
              end else begin
                busy <= 1'b1;
                if (shreg[0])    state <= S_RDATA;
                else if (ADDR16) state <= S_SUBH;
                else             state <= S_SUBL;
              end
            end
            S_SUBH: begin
              sub_hi <= shreg;
              state  <= S_SUBL;
            end
            S_SUBL: begin
              ptr   <= REG_AW'(ADDR16 ? {sub_hi, shreg} : {8'h00, shreg});
              state <= S_WDATA;
            end
            S_WDATA: begin
              reg_wr    <= 1'b1;
              reg_waddr <= ptr;
              reg_wdata <= shreg;
              ptr       <= ptr + 1'b1;
            end
            S_RDATA: begin
              if (d_sh[1]) state <= S_WAIT_STOP;
              else         ptr   <= ptr + 1'b1;
            end
            default: ;
          endcase
        end
      end else if (scl_fall) begin
        sccb_data_out <= 1'b1;
        sccb_data_en  <= 1'b0;
        if (state == S_RDATA && bit_cnt != 4'd8) begin
          sccb_data_out <= rd_bit;
          sccb_data_en  <= 1'b1;
        end else if (ACK_EN && bit_cnt == 4'd8 && ack_slot) begin
          sccb_data_out <= 1'b0;
          sccb_data_en  <= 1'b1;
        end
      end
    end
  end

  // Memory commits one cycle after reg_wr, so a coincident local read sees the old byte
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      loc_rdata <= 8'h00;
    end else begin
      loc_rdata <= mem[loc_addr];
      if (reg_wr) mem[reg_waddr] <= reg_wdata;
    end
  end

endmodule
